// File: rtl/mii_frame_checker.sv
// rtl/mii_frame_checker.sv - MII frame checker: payload length, EOF/idle framing and saturating frame counters
module mii_frame_checker #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter logic [7:0]  IDLE_CODE         = 8'h07,
  parameter logic [7:0]  START_CODE        = 8'hFB,
  parameter logic [7:0]  EOF_CODE          = 8'hFD,
  parameter int          MIN_PAYLOAD_BYTES = 40,
  parameter int          MAX_PAYLOAD_BYTES = 136,
  parameter int          CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
  input  logic                  i_clear_counters,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  o_frame_bytes,
  output logic                  o_error,
  output logic                  o_err_short,
  output logic                  o_err_long,
  output logic                  o_err_no_eof,
  output logic                  o_err_ctrl,
  output logic [CNT_WIDTH-1:0]  o_good_count,
  output logic [CNT_WIDTH-1:0]  o_bad_count
);

  localparam int LANE_W = $clog2(CTRL_WIDTH);
  localparam logic [0:0] WAIT_START = 1'b0;
  localparam logic [0:0] COUNT_DATA = 1'b1;
  localparam logic [CNT_WIDTH:0]   WORD_BYTES = (CNT_WIDTH + 1)'(DATA_WIDTH / 8);
  localparam logic [CNT_WIDTH-1:0] MIN_P      = CNT_WIDTH'(MIN_PAYLOAD_BYTES);
  localparam logic [CNT_WIDTH-1:0] MAX_P      = CNT_WIDTH'(MAX_PAYLOAD_BYTES);

  logic [0:0]           state, next_state;
  logic [CNT_WIDTH-1:0] byte_cnt, next_cnt;

  logic                 any_ctrl, is_start, tail_bad;
  logic [LANE_W-1:0]    low_lane;
  logic [7:0]           low_byte;
  logic [CNT_WIDTH:0]   sum_word, sum_lane;
  logic [CNT_WIDTH-1:0] cnt_plus_word, payload;

  logic                 close, c_short, c_long, c_no_eof, c_ctrl, c_err;
  logic [CNT_WIDTH-1:0] c_bytes;

  assign any_ctrl = |i_tx_ctrl;
  assign is_start = i_tx_ctrl[0] && (i_tx_data[7:0] == START_CODE);

  // Lowest control lane, and whether every lane above it is a proper idle
  always_comb begin
    low_lane = '0;
    low_byte = '0;
    for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
      if (i_tx_ctrl[i]) begin
        low_lane = LANE_W'(i);
        low_byte = i_tx_data[8*i +: 8];
      end
    end
    tail_bad = 1'b0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (i > int'(low_lane) && !(i_tx_ctrl[i] && (i_tx_data[8*i +: 8] == IDLE_CODE)))
        tail_bad = 1'b1;
    end
  end

  assign sum_word      = {1'b0, byte_cnt} + WORD_BYTES;
  assign cnt_plus_word = sum_word[CNT_WIDTH] ? '1 : sum_word[CNT_WIDTH-1:0];
  assign sum_lane      = {1'b0, byte_cnt} + (CNT_WIDTH + 1)'(low_lane);
  assign payload       = sum_lane[CNT_WIDTH] ? '1 : sum_lane[CNT_WIDTH-1:0];

  always_comb begin
    next_state = state;
    next_cnt   = byte_cnt;
    close      = 1'b0;
    c_bytes    = '0;
    c_short    = 1'b0;
    c_long     = 1'b0;
    c_no_eof   = 1'b0;
    c_ctrl     = 1'b0;
    case (state)
      WAIT_START: begin
        if (is_start) begin
          next_state = COUNT_DATA;
          next_cnt   = '0;
        end
      end
      default: begin
        if (!any_ctrl) begin
          next_cnt = cnt_plus_word;
        end else if (is_start) begin
          // Back-to-back START: old frame is abandoned, new one begins now
          close    = 1'b1;
          c_bytes  = byte_cnt;
          c_no_eof = 1'b1;
          next_cnt = '0;
        end else begin
          close      = 1'b1;
          c_bytes    = payload;
          next_state = WAIT_START;
          if (low_byte == EOF_CODE) begin
            c_ctrl  = tail_bad;
            c_short = payload < MIN_P;
            c_long  = payload > MAX_P;
          end else begin
            c_ctrl = 1'b1;
          end
        end
      end
    endcase
  end

  assign c_err = c_short | c_long | c_no_eof | c_ctrl;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= WAIT_START;
      byte_cnt      <= '0;
      o_frame_done  <= 1'b0;
      o_frame_bytes <= '0;
      o_error       <= 1'b0;
      o_err_short   <= 1'b0;
      o_err_long    <= 1'b0;
      o_err_no_eof  <= 1'b0;
      o_err_ctrl    <= 1'b0;
      o_good_count  <= '0;
      o_bad_count   <= '0;
    end else begin
      state        <= next_state;
      byte_cnt     <= next_cnt;
      o_frame_done <= close;
      o_error      <= close & c_err;
      o_err_short  <= close & c_short;
      o_err_long   <= close & c_long;
      o_err_no_eof <= close & c_no_eof;
      o_err_ctrl   <= close & c_ctrl;
      if (close)
        o_frame_bytes <= c_bytes;
      if (i_clear_counters) begin
        o_good_count <= '0;
        o_bad_count  <= '0;
      end else if (close) begin
        if (c_err) begin
          if (o_bad_count != '1) o_bad_count <= o_bad_count + 1'b1;
        end else begin
          if (o_good_count != '1) o_good_count <= o_good_count + 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (o_error)
      $display("%m: t=%0t short=%b long=%b no_eof=%b ctrl=%b bytes=%0d",
               $time, o_err_short, o_err_long, o_err_no_eof, o_err_ctrl, o_frame_bytes);
  end
`endif

endmodule

// File: tb/tb_mii_frame_checker.sv
// tb/tb_mii_frame_checker.sv - directed bench for mii_frame_checker with immediate assertions
module tb_mii_frame_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_tx_data;
  logic [7:0]  i_tx_ctrl;
  logic        i_clear_counters;
  logic        o_frame_done, o_error, o_err_short, o_err_long, o_err_no_eof, o_err_ctrl;
  logic [15:0] o_frame_bytes, o_good_count, o_bad_count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] START_W = 64'h07070707070707FB;
  localparam logic [63:0] DATA_W  = 64'h0102030405060708;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;

  mii_frame_checker dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_tx_data        (i_tx_data),
    .i_tx_ctrl        (i_tx_ctrl),
    .i_clear_counters (i_clear_counters),
    .o_frame_done     (o_frame_done),
    .o_frame_bytes    (o_frame_bytes),
    .o_error          (o_error),
    .o_err_short      (o_err_short),
    .o_err_long       (o_err_long),
    .o_err_no_eof     (o_err_no_eof),
    .o_err_ctrl       (o_err_ctrl),
    .o_good_count     (o_good_count),
    .o_bad_count      (o_bad_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    i_tx_data = d;
    i_tx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic start_and_data(input int n);
    step(START_W, 8'hFF);
    for (int i = 0; i < n; i++) step(DATA_W, 8'h00);
  endtask

  // EOF in lane k, data bytes below it, idles above it
  task automatic send_eof(input int k);
    logic [63:0] d;
    logic [7:0]  c;
    for (int i = 0; i < 8; i++) begin
      if (i < k)       begin d[8*i +: 8] = 8'hAA; c[i] = 1'b0; end
      else if (i == k) begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
      else             begin d[8*i +: 8] = 8'h07; c[i] = 1'b1; end
    end
    step(d, c);
  endtask

  initial begin
    i_rst = 1'b1;
    i_tx_data = IDLE_W;
    i_tx_ctrl = 8'hFF;
    i_clear_counters = 1'b0;
    step(IDLE_W, 8'hFF);
    step(IDLE_W, 8'hFF);
    check("rst_done", o_frame_done, 0);
    check("rst_error", o_error, 0);
    check("rst_bytes", o_frame_bytes, 0);
    check("rst_good", o_good_count, 0);
    check("rst_bad", o_bad_count, 0);
    i_rst = 1'b0;

    step(IDLE_W, 8'hFF);
    check("idle_no_done", o_frame_done, 0);

    // 40-byte minimum frame
    start_and_data(5);
    check("data_no_done", o_frame_done, 0);
    send_eof(0);
    check("f40_done", o_frame_done, 1);
    check("f40_bytes", o_frame_bytes, 40);
    check("f40_error", o_error, 0);
    check("f40_good", o_good_count, 1);
    step(IDLE_W, 8'hFF);
    check("f40_pulse_one_cycle", o_frame_done, 0);

    // 137 bytes: too long
    start_and_data(17);
    send_eof(1);
    check("f137_bytes", o_frame_bytes, 137);
    check("f137_long", o_err_long, 1);
    check("f137_error", o_error, 1);
    check("f137_short", o_err_short, 0);
    check("f137_bad", o_bad_count, 1);

    // 136 bytes: maximum is legal
    start_and_data(17);
    send_eof(0);
    check("f136_bytes", o_frame_bytes, 136);
    check("f136_error", o_error, 0);
    check("f136_good", o_good_count, 2);

    // 39 bytes: too short
    start_and_data(4);
    send_eof(7);
    check("f39_bytes", o_frame_bytes, 39);
    check("f39_short", o_err_short, 1);
    check("f39_error", o_error, 1);
    check("f39_bad", o_bad_count, 2);

    // START inside a frame
    start_and_data(3);
    step(START_W, 8'hFF);
    check("noeof_done", o_frame_done, 1);
    check("noeof_flag", o_err_no_eof, 1);
    check("noeof_bytes", o_frame_bytes, 24);
    check("noeof_bad", o_bad_count, 3);
    for (int i = 0; i < 5; i++) step(DATA_W, 8'h00);
    send_eof(0);
    check("restart_bytes", o_frame_bytes, 40);
    check("restart_error", o_error, 0);
    check("restart_good", o_good_count, 3);

    // EOF lane 3 followed by a non-idle control lane
    start_and_data(6);
    step(64'h07070700FDAAAAAA, 8'hF8);
    check("badtail_bytes", o_frame_bytes, 51);
    check("badtail_ctrl", o_err_ctrl, 1);
    check("badtail_short", o_err_short, 0);
    check("badtail_error", o_error, 1);
    check("badtail_bad", o_bad_count, 4);

    // Clear wins over a simultaneous good close
    start_and_data(5);
    i_clear_counters = 1'b1;
    send_eof(0);
    i_clear_counters = 1'b0;
    check("clr_done", o_frame_done, 1);
    check("clr_good", o_good_count, 0);
    check("clr_bad", o_bad_count, 0);

    // Stray control character mid-frame
    start_and_data(5);
    step(64'h0707070707AAAAAA, 8'hF8);
    check("stray_done", o_frame_done, 1);
    check("stray_ctrl", o_err_ctrl, 1);
    check("stray_bytes", o_frame_bytes, 43);
    check("stray_bad", o_bad_count, 1);
    send_eof(0);
    check("stray_back_to_wait", o_frame_done, 0);

    // Reset mid-frame discards it
    start_and_data(3);
    i_rst = 1'b1;
    step(DATA_W, 8'h00);
    i_rst = 1'b0;
    check("rstmid_done", o_frame_done, 0);
    check("rstmid_error", o_error, 0);
    check("rstmid_bad", o_bad_count, 0);
    step(DATA_W, 8'h00);
    step(DATA_W, 8'h00);
    send_eof(0);
    check("rstmid_eof_ignored", o_frame_done, 0);
    start_and_data(5);
    send_eof(0);
    check("rstmid_clean_done", o_frame_done, 1);
    check("rstmid_clean_bytes", o_frame_bytes, 40);
    check("rstmid_clean_good", o_good_count, 1);
    check("rstmid_clean_bad", o_bad_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mii_frame_checker.md
MII_FRAME_CHECKER -- requirements
Module: mii_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning data bus width in bits (multiple of 8, 32..256).
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning one control bit per byte lane.
REQ-003 SHALL have parameters IDLE_CODE, START_CODE, EOF_CODE, defaults 8'h07, 8'hFB, 8'hFD, meaning the control characters.
REQ-004 SHALL have parameters MIN_PAYLOAD_BYTES, MAX_PAYLOAD_BYTES, defaults 40, 136, meaning the legal payload range in bytes, inclusive.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the byte and frame counters.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 i_tx_data  input  DATA_WIDTH  MII data; lane n = bits [8n+7:8n].
REQ-009 i_tx_ctrl  input  CTRL_WIDTH  bit n=1 marks lane n as a control character.
REQ-010 i_clear_counters  input  1  synchronous clear of o_good_count and o_bad_count.
REQ-011 o_frame_done  output  1  one-cycle pulse when a frame closes, good or bad.
REQ-012 o_frame_bytes  output  CNT_WIDTH  payload byte count of the closed frame; valid with o_frame_done.
REQ-013 o_error  output  1  one-cycle pulse; OR of the four error flags.
REQ-014 o_err_short / o_err_long / o_err_no_eof / o_err_ctrl  output  1 each  error cause; valid with o_error.
REQ-015 o_good_count / o_bad_count  output  CNT_WIDTH each  saturating frame counters.

Function
REQ-016 SHALL implement FSM states WAIT_START and COUNT_DATA.
REQ-017 WAIT_START->COUNT_DATA when lane 0 = START_CODE and ctrl[0]=1: byte counter cleared; the rest of the start word is ignored and not counted.
REQ-018 WAIT_START with any other word: no action, no error.
REQ-019 COUNT_DATA with ctrl==0: byte counter += DATA_WIDTH/8, saturating at 2^CNT_WIDTH-1.
REQ-020 EOF word = lowest lane k with ctrl[k]=1 holds EOF_CODE. Payload = counter + k. Frame closes; FSM->WAIT_START.
REQ-021 EOF word SHALL be checked: lanes >k must be ctrl=1 with IDLE_CODE, else o_err_ctrl.
REQ-022 At EOF: payload < MIN_PAYLOAD_BYTES -> o_err_short; payload > MAX_PAYLOAD_BYTES -> o_err_long; boundary values are legal.
REQ-023 COUNT_DATA, lane 0 = START_CODE with ctrl[0]=1: close the current frame with o_err_no_eof, o_frame_bytes = counter; start a new frame in the same cycle (counter cleared, stay in COUNT_DATA).
REQ-024 COUNT_DATA, lowest control lane is neither EOF_CODE nor a START in lane 0: close the frame with o_err_ctrl, o_frame_bytes = counter + lane index; FSM->WAIT_START.
REQ-025 Multiple flags SHALL assert together when several conditions hold (e.g. short + ctrl).
REQ-026 All outputs SHALL be registered: each flag and pulse asserts exactly one cycle after the closing word is sampled.
REQ-027 Frame with no error -> o_good_count+1; frame with any error -> o_bad_count+1; both hold at all-ones.
REQ-028 i_clear_counters SHALL zero both counters next cycle; clear with a simultaneous increment -> result 0.
REQ-029 Simulation-only $display SHALL report time, cause and byte count on each o_error, excluded under SYNTHESIS.

Reset
REQ-030 When i_rst=1 at a clk edge: FSM=WAIT_START, byte counter=0, all pulses and flags=0, o_frame_bytes=0, o_good_count=o_bad_count=0.
REQ-031 A frame in progress when reset asserts SHALL be discarded with no o_frame_done or o_error.
REQ-032 Reset SHALL take priority over i_clear_counters and all data input.

Verification (DATA_WIDTH=64)
REQ-033 START, 5 data words, EOF lane 0 + idles -> o_frame_done, bytes=40, no error, good_count=1.
REQ-034 START, 17 data words, EOF lane 1 -> bytes=137, o_err_long=1, o_error=1, bad_count=1; same with EOF lane 0 -> 136, good.
REQ-035 START, 4 data words, EOF lane 7 -> bytes=39, o_err_short=1.
REQ-036 START, 3 data words, START again, then 5 words + EOF lane 0 -> first frame o_err_no_eof with bytes=24; second frame good with bytes=40; good=1, bad=1.
REQ-037 START, 6 words, EOF lane 3 with lane 4 ctrl=1 data 8'h00 -> bytes=51, o_err_ctrl=1; then i_clear_counters in the same cycle as a good close -> counts 0.
REQ-038 i_rst pulsed mid-frame after 3 words, then a clean 40-byte frame -> no pulse for the aborted frame; good_count=1.
